// File: rtl/bist_response_checker.sv
// Response-side BIST checker. It folds each qualified CUT output vector into a MISR.
// After N_VEC vectors it freezes the signature and reports pass/fail against GOLDEN.
module bist_response_checker #(
  parameter int               N_OUT  = 2,
  parameter int               N_VEC  = 8,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D,
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter logic [SIG_W-1:0] GOLDEN = '0,
  localparam int              CW     = $clog2(N_VEC + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CW-1:0]    vec_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_nxt;
  logic [SIG_W-1:0] resp_ext;
  logic [CW-1:0]    cnt_q;
  logic             pass_q;
  logic             last_vec;

  // One MISR step: Galois shift with POLY feedback, then XOR in the response vector.
  always_comb begin
    resp_ext             = '0;
    resp_ext[N_OUT-1:0]  = resp;
    sig_nxt              = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
  end

  assign last_vec = (cnt_q == CW'(N_VEC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sig_q  <= SEED;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          // A start pulse takes priority over a vector arriving in the same cycle.
          if (start) begin
            state  <= RUN;
            sig_q  <= SEED;
            cnt_q  <= '0;
            pass_q <= 1'b0;
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_q <= sig_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last_vec) begin
              state  <= FINISH;
              pass_q <= (sig_nxt == GOLDEN);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == FINISH);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule
